// File: rtl/sfu_conv_acc.sv
// Output-stationary convolution accumulator: folds a stream of per-tap partial sums
// into MIJ x CH accumulators, then drains them with optional ReLU and saturation.
module sfu_conv_acc #(
    parameter int PSUM_BW = 16,
    parameter int ACC_BW  = 20,
    parameter int CH      = 4,
    parameter int IN_W    = 6,
    parameter int K       = 3,
    localparam int OUT_W  = IN_W - K + 1,
    localparam int NIJ    = IN_W * IN_W,
    localparam int KIJ    = K * K,
    localparam int MIJ    = OUT_W * OUT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    relu_en,
    input  logic                    i_valid,
    input  logic [CH*PSUM_BW-1:0]   i_data,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [CH*PSUM_BW-1:0]   o_data,
    output logic [$clog2(MIJ)-1:0]  o_idx,
    output logic                    busy,
    output logic                    done
);

    localparam int RW = $clog2(IN_W + 1);
    localparam int PW = $clog2(MIJ);

    localparam logic signed [ACC_BW-1:0] SAT_MAX =
        {{(ACC_BW-PSUM_BW+1){1'b0}}, {(PSUM_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0] SAT_MIN =
        {{(ACC_BW-PSUM_BW+1){1'b1}}, {(PSUM_BW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t            state;
    logic [RW-1:0]     in_r, in_c, k_r, k_c;
    logic              relu_q;
    logic [ACC_BW-1:0] acc [MIJ][CH];

    logic [RW-1:0]     o_r, o_c;
    logic              hit;
    logic [PW-1:0]     pix;
    logic              last_in, last_k;

    // Row/column counters replace nij/kij so no divider is needed for r, c, kr, kc.
    always_comb begin
        o_r     = in_r - k_r;
        o_c     = in_c - k_c;
        hit     = (in_r >= k_r) && (in_c >= k_c) &&
                  (o_r < RW'(OUT_W)) && (o_c < RW'(OUT_W));
        pix     = PW'(int'(o_r) * OUT_W + int'(o_c));
        last_in = (in_r == RW'(IN_W - 1)) && (in_c == RW'(IN_W - 1));
        last_k  = (k_r == RW'(K - 1)) && (k_c == RW'(K - 1));
    end

    assign busy = (state != IDLE);

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order inside the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            in_r    <= '0;
            in_c    <= '0;
            k_r     <= '0;
            k_c     <= '0;
            relu_q  <= 1'b0;
            o_valid <= 1'b0;
            o_idx   <= '0;
            done    <= 1'b0;
            // NOTE: the accumulator array is plain flops, so clearing it in reset is
            // legal here; a RAM-backed version would need a clear sweep instead.
            for (int p = 0; p < MIJ; p++)
                for (int l = 0; l < CH; l++)
                    acc[p][l] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int p = 0; p < MIJ; p++)
                            for (int l = 0; l < CH; l++)
                                acc[p][l] <= '0;
                        in_r   <= '0;
                        in_c   <= '0;
                        k_r    <= '0;
                        k_c    <= '0;
                        relu_q <= relu_en;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (i_valid) begin
                        if (hit)
                            for (int l = 0; l < CH; l++)
                                acc[pix][l] <= acc[pix][l] +
                                    ACC_BW'(signed'(i_data[l*PSUM_BW +: PSUM_BW]));
                        if (last_in) begin
                            in_r <= '0;
                            in_c <= '0;
                            if (last_k) begin
                                k_r     <= '0;
                                k_c     <= '0;
                                o_idx   <= '0;
                                o_valid <= 1'b1;
                                state   <= DRAIN;
                            end else if (k_c == RW'(K - 1)) begin
                                k_c <= '0;
                                k_r <= k_r + RW'(1);
                            end else begin
                                k_c <= k_c + RW'(1);
                            end
                        end else if (in_c == RW'(IN_W - 1)) begin
                            in_c <= '0;
                            in_r <= in_r + RW'(1);
                        end else begin
                            in_c <= in_c + RW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (o_ready) begin
                        if (o_idx == PW'(MIJ - 1)) begin
                            o_valid <= 1'b0;
                            o_idx   <= '0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            o_idx <= o_idx + PW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output stage reads the addressed pixel directly; accumulators are frozen in DRAIN.
    always_comb begin
        logic signed [ACC_BW-1:0] a;
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        o_data = '0;
        a      = '0;
        if (o_valid) begin
            for (int l = 0; l < CH; l++) begin
                a = signed'(acc[o_idx][l]);
                if (relu_q && a < 0)
                    o_data[l*PSUM_BW +: PSUM_BW] = '0;
                else if (a > SAT_MAX)
                    o_data[l*PSUM_BW +: PSUM_BW] = SAT_MAX[PSUM_BW-1:0];
                else if (a < SAT_MIN)
                    o_data[l*PSUM_BW +: PSUM_BW] = SAT_MIN[PSUM_BW-1:0];
                else
                    o_data[l*PSUM_BW +: PSUM_BW] = a[PSUM_BW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_sfu_conv_acc.sv
// Scoreboard bench for sfu_conv_acc: stimulus pushes expected pixels, a negedge
// monitor pops and compares them on every output handshake.
module tb_sfu_conv_acc;

    localparam int DW  = 64;
    localparam int MIJ = 16;

    logic          clk = 1'b0;
    logic          reset, start, relu_en, i_valid, o_ready;
    logic [DW-1:0] i_data, o_data;
    logic          o_valid, busy, done;
    logic [3:0]    o_idx;

    always #5 clk = ~clk;

    sfu_conv_acc dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .relu_en (relu_en),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_idx   (o_idx),
        .busy    (busy),
        .done    (done)
    );

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          done_cnt = 0;
    logic [15:0] lane_val [4];
    bit          sparse;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compare every accepted output against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (done) done_cnt++;
            if (o_valid && o_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: idx %0d data %h with empty scoreboard", o_idx, o_data);
                end else begin
                    e = sb.pop_front();
                    check("o_idx", DW'(o_idx), DW'(e.idx));
                    check("o_data", o_data, e.data);
                end
            end
        end
    end

    function automatic logic [DW-1:0] gen(input int kij, input int nij);
        logic [15:0] v;
        if (sparse) begin
            v = (kij == 0 && nij == 0) ? 16'd5 : (kij == 8 && nij == 35) ? 16'd7 : 16'd0;
            return {4{v}};
        end
        return {lane_val[3], lane_val[2], lane_val[1], lane_val[0]};
    endfunction

    task automatic push_uniform(input logic [DW-1:0] d);
        for (int i = 0; i < MIJ; i++) sb.push_back('{i, d});
    endtask

    // One pass: start (with a junk i_valid word that must be discarded), 324 inputs
    // with periodic gaps, then wait for done. abort_after > 0 stops feeding early.
    task automatic run_pass(input logic relu, input int abort_after);
        int d0, n, t;
        d0 = done_cnt;
        n  = 0;
        @(posedge clk); #1;
        start = 1'b1; relu_en = relu; i_valid = 1'b1; i_data = {4{16'h0100}};
        @(posedge clk); #1;
        start = 1'b0; relu_en = ~relu; i_valid = 1'b0;
        for (int kij = 0; kij < 9; kij++) begin
            for (int nij = 0; nij < 36; nij++) begin
                if (nij % 7 == 3) begin
                    i_valid = 1'b0; i_data = {4{16'h0300}};
                    @(posedge clk); #1;
                end
                i_valid = 1'b1;
                i_data  = gen(kij, nij);
                @(posedge clk); #1;
                n++;
                if (n == abort_after) begin
                    i_valid = 1'b0;
                    return;
                end
            end
        end
        i_valid = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        check("done_pulse_count", DW'(done_cnt - d0), DW'(1));
        check("busy_after_done", DW'(busy), DW'(0));
        check("scoreboard_empty", DW'(sb.size()), DW'(0));
    endtask

    task automatic backpressure();
        int t;
        t = 0;
        while (!(o_valid && o_idx == 4'd5) && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        check("reach_idx5", DW'(o_valid && o_idx == 4'd5), DW'(1));
        o_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("hold_idx", DW'(o_idx), DW'(5));
            check("hold_data", o_data, {4{16'h0009}});
            check("hold_valid", DW'(o_valid), DW'(1));
        end
        o_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; relu_en = 1'b0; i_valid = 1'b0; o_ready = 1'b1;
        i_data = '0; sparse = 1'b0;
        lane_val = '{16'h1, 16'h1, 16'h1, 16'h1};
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_o_valid", DW'(o_valid), DW'(0));
        check("rst_done", DW'(done), DW'(0));
        check("rst_o_idx", DW'(o_idx), DW'(0));
        check("rst_o_data", o_data, DW'(0));
        reset = 1'b0;

        // All ones: each pixel sees 9 taps.
        push_uniform({4{16'h0009}});
        run_pass(1'b0, -1);

        // All -1 with ReLU, then without.
        lane_val = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        push_uniform(64'h0);
        run_pass(1'b1, -1);
        push_uniform({4{16'hFFF7}});
        run_pass(1'b0, -1);

        // 9 * 32767 = 294903 saturates to 0x7FFF.
        lane_val = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        push_uniform({4{16'h7FFF}});
        run_pass(1'b0, -1);

        // Mixed lanes with ReLU: 9, 18, -9 -> 0, 27.
        lane_val = '{16'h0001, 16'h0002, 16'hFFFF, 16'h0003};
        push_uniform(64'h001B_0000_0012_0009);
        run_pass(1'b1, -1);

        // Corner taps only.
        sparse = 1'b1;
        for (int i = 0; i < MIJ; i++)
            sb.push_back('{i, (i == 0) ? {4{16'd5}} : (i == 15) ? {4{16'd7}} : 64'h0});
        run_pass(1'b0, -1);
        sparse = 1'b0;

        // Backpressure at o_idx 5.
        lane_val = '{16'h1, 16'h1, 16'h1, 16'h1};
        push_uniform({4{16'h0009}});
        fork
            run_pass(1'b0, -1);
            backpressure();
        join

        // Reset mid-ACCUM, then a clean run.
        lane_val = '{16'h0040, 16'h0040, 16'h0040, 16'h0040};
        run_pass(1'b0, 100);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_busy", DW'(busy), DW'(0));
        check("midrst_o_valid", DW'(o_valid), DW'(0));
        check("midrst_o_data", o_data, DW'(0));
        reset = 1'b0;
        lane_val = '{16'h1, 16'h1, 16'h1, 16'h1};
        push_uniform({4{16'h0009}});
        run_pass(1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sfu_conv_acc.md
SFU_CONV_ACC -- requirements
Module: sfu_conv_acc

Interface
REQ-001 SHALL have parameter PSUM_BW, default 16: width of each input psum and output lane, two's complement.
REQ-002 SHALL have parameter ACC_BW, default 20: internal accumulator width, ACC_BW >= PSUM_BW.
REQ-003 SHALL have parameter CH, default 4: number of output channels processed in parallel lanes.
REQ-004 SHALL have parameter IN_W, default 6: input feature-map side length.
REQ-005 SHALL have parameter K, default 3: kernel side length, K <= IN_W.
REQ-006 SHALL derive localparams OUT_W = IN_W-K+1, NIJ = IN_W*IN_W, KIJ = K*K, MIJ = OUT_W*OUT_W.
REQ-007 SHALL have port clk, input, 1: clock, all state updates on the rising edge.
REQ-008 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port start, input, 1: one-cycle request to begin a new accumulation pass.
REQ-010 SHALL have port relu_en, input, 1: enables ReLU on drained outputs; sampled when start is accepted.
REQ-011 SHALL have port i_valid, input, 1: i_data holds one psum word per lane this cycle.
REQ-012 SHALL have port i_data, input, CH*PSUM_BW: lane c at bits [c*PSUM_BW +: PSUM_BW].
REQ-013 SHALL have port o_valid, output, 1: o_data and o_idx hold a drained output.
REQ-014 SHALL have port o_ready, input, 1: downstream accepts the output when o_valid and o_ready are both high.
REQ-015 SHALL have port o_data, output, CH*PSUM_BW: post-processed output pixel, same lane packing as i_data.
REQ-016 SHALL have port o_idx, output, $clog2(MIJ): output pixel index, row-major.
REQ-017 SHALL have port busy, output, 1: high in ACCUM or DRAIN.
REQ-018 SHALL have port done, output, 1: one-cycle pulse after the last output handshake.

Function
REQ-019 SHALL implement states IDLE, ACCUM, DRAIN.
REQ-020 IDLE: start SHALL clear all MIJ*CH accumulators, zero nij/kij counters, latch relu_en, and go to ACCUM next cycle; start SHALL be ignored in ACCUM and DRAIN.
REQ-021 ACCUM: each i_valid cycle SHALL be one input at nij = nij_cnt (r = nij/IN_W, c = nij%IN_W) for kernel tap kij = kij_cnt (kr = kij/K, kc = kij%K).
REQ-022 If 0 <= r-kr < OUT_W and 0 <= c-kc < OUT_W, each lane SHALL add its sign-extended input to acc[(r-kr)*OUT_W + (c-kc)]; otherwise the input SHALL be discarded.
REQ-023 Accumulation SHALL wrap modulo 2^ACC_BW, with the result visible one cycle after the i_valid edge.
REQ-024 nij_cnt SHALL wrap from NIJ-1 to 0 and increment kij_cnt; on the input with kij_cnt = KIJ-1 and nij_cnt = NIJ-1, the block SHALL go to DRAIN.
REQ-025 i_valid SHALL be ignored in IDLE and DRAIN, and i_valid-low cycles SHALL not advance the counters.
REQ-026 DRAIN: o_valid SHALL be high with o_idx starting at 0; on each o_valid && o_ready, o_idx SHALL increment.
REQ-027 While o_valid is high and o_ready is low, o_data and o_idx SHALL hold stable.
REQ-028 Per lane, o_data SHALL be 0 if relu_en is latched and acc < 0; otherwise acc saturated to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1].
REQ-029 The handshake at o_idx = MIJ-1 SHALL drop o_valid, pulse done, and return to IDLE the next cycle.
REQ-030 start and i_valid asserted together in IDLE SHALL accept start only; the i_valid word SHALL be discarded.

Reset
REQ-031 reset SHALL force IDLE, zero all counters and accumulators, and drive o_valid=0, done=0, busy=0, o_idx=0, o_data=0.
REQ-032 reset SHALL take priority over start, i_valid, and o_ready in any state, including mid-ACCUM and mid-DRAIN.

Verification
REQ-033 Default parameters, all inputs 1 on every lane, o_ready=1 -> 16 outputs, each lane = 9, o_idx 0..15, then done pulse.
REQ-034 All inputs 0xFFFF: relu_en=1 gives every lane = 0; relu_en=0 gives every lane = 0xFFF7 (-9).
REQ-035 All inputs 0x7FFF, relu_en=0 -> accumulator 294903, every lane = 0x7FFF (saturated).
REQ-036 Single nonzero input 5 at (kij=0, nij=0) and 7 at (kij=8, nij=35), all others 0 -> o_idx 0 = 5, o_idx 15 = 7, all other pixels 0.
REQ-037 o_ready low for 3 cycles while o_idx = 5 -> o_idx and o_data held; drain resumes at 5 with no pixel lost or repeated.
REQ-038 reset asserted after 100 ACCUM inputs, then a fresh all-ones run -> busy=0 after reset; the new run outputs 9 per lane.
